// File: rtl/dram_wr_gen.sv
// AXI4 write-traffic generator: writes burst_len beats of a replicated 32-bit pattern
// from an aligned base address, in chunks of at most MAX_BEATS, one burst in flight.
module dram_wr_gen #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int ID_W      = 16,
    parameter int MAX_BEATS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         start_addr,
    input  logic [31:0]         burst_len,
    input  logic [31:0]         write_val,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         cycle_count,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int                BYTES       = DATA_W / 8;
    localparam logic [2:0]        AWSIZE      = 3'($clog2(BYTES));
    localparam logic [ADDR_W-1:0] CHUNK_BYTES = ADDR_W'(MAX_BEATS * BYTES);
    // Base is aligned to a full chunk so no burst straddles a 4 KB page at default sizes.
    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~(CHUNK_BYTES - ADDR_W'(1));

    typedef enum logic [2:0] {IDLE, AW, W, B, FIN} state_t;

    state_t      state;
    logic [31:0] remaining;
    logic [31:0] next_rem;
    logic [8:0]  chunk;
    logic [8:0]  beats_left;
    logic        bid_unused;

    function automatic logic [8:0] chunk_of(input logic [31:0] rem);
        return (rem > 32'(MAX_BEATS)) ? 9'(MAX_BEATS) : rem[8:0];
    endfunction

    assign awid       = '0;
    assign next_rem   = remaining - 32'(chunk);
    assign bid_unused = ^bid;

    // NOTE: every register here, state and outputs alike, is assigned with <= so all
    // updates in one edge see the same pre-edge values; there is no memory, so the
    // synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            chunk       <= '0;
            beats_left  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            awsize      <= '0;
            awburst     <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wlast       <= 1'b0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
        end else begin
            if (busy && cycle_count != '1)
                cycle_count <= cycle_count + 32'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= burst_len;
                        wdata       <= {(DATA_W/32){write_val}};
                        wstrb       <= '1;
                        awsize      <= AWSIZE;
                        awburst     <= 2'b01;
                        awaddr      <= ADDR_W'(start_addr) & ALIGN_MASK;
                        chunk       <= chunk_of(burst_len);
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        cycle_count <= '0;
                        if (burst_len == '0) begin
                            state <= FIN;
                        end else begin
                            awlen   <= 8'(chunk_of(burst_len) - 9'd1);
                            awvalid <= 1'b1;
                            state   <= AW;
                        end
                    end
                end

                AW: begin
                    if (awready) begin
                        awvalid    <= 1'b0;
                        wvalid     <= 1'b1;
                        wlast      <= (chunk == 9'd1);
                        beats_left <= chunk;
                        state      <= W;
                    end
                end

                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            beats_left <= beats_left - 9'd1;
                            wlast      <= (beats_left == 9'd2);
                        end
                    end
                end

                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        err       <= err | (bresp != 2'b00);
                        remaining <= next_rem;
                        if (next_rem != '0) begin
                            awaddr  <= awaddr + CHUNK_BYTES;
                            chunk   <= chunk_of(next_rem);
                            awlen   <= 8'(chunk_of(next_rem) - 9'd1);
                            awvalid <= 1'b1;
                            state   <= AW;
                        end else begin
                            state <= FIN;
                        end
                    end
                end

                // busy falls and done rises on the same edge; this edge is still counted.
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_wr_gen.md
Name: dram_wr_gen

Overview:
- Write-traffic generator directly downstream of the perf-test register file; consumes its start_addr, burst_len and write_val outputs.
- On a start pulse, writes burst_len beats of a fixed pattern to DRAM over an AXI4 write-master port.
- Splits the transfer into chunks of at most MAX_BEATS beats and issues one burst at a time.
- Reports busy/done, the total cycle count and a sticky error flag for throughput measurement.

Parameters:
DATA_W, 512, AXI data width in bits; multiple of 32
ADDR_W, 64, AXI address width; start_addr is zero-extended to it
ID_W, 16, AXI ID width; awid is driven constant 0
MAX_BEATS, 64, max beats per AXI burst; power of 2, 1..256

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; launches a run
start_addr  in  32  byte address of first beat
burst_len  in  32  total beats to write
write_val  in  32  pattern replicated across every 32-bit lane
busy  out  1  run in progress
done  out  1  sticky; set at run end, cleared by next accepted start
err  out  1  sticky; any bresp != OKAY in the current run
cycle_count  out  32  cycles from accepted start to run end
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/ADDR_W/8/3/2/1  AXI AW channel
awready  in  1  AXI AW ready
wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  AXI W channel
wready  in  1  AXI W ready
bid/bresp/bvalid  in  ID_W/2/1  AXI B channel
bready  out  1  AXI B ready

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all internal counters cleared. Asserting rst mid-run aborts it immediately: valids drop the next cycle, no wlast is completed.
- Start: start is accepted only in IDLE. On acceptance the block latches start_addr, burst_len and write_val.
  - It clears done, err and cycle_count and sets busy.
  - start while busy is ignored.
- Alignment: latched address low log2(MAX_BEATS*DATA_W/8) bits are forced to 0, so a chunk never crosses a 4 KB boundary at default parameters.
- FSM states and transitions:
  - IDLE: wait for start. If start and burst_len==0, go to FIN with no AXI activity.
  - AW: awvalid=1 until awready. awaddr = base + chunk_idx*MAX_BEATS*DATA_W/8. awlen = min(remaining, MAX_BEATS)-1. awsize = log2(DATA_W/8); awburst = INCR.
  - W: wvalid=1. Each wvalid&wready advances the beat counter. wlast=1 on the chunk's final beat; W->B after the wlast handshake.
  - B: bready=1. On bvalid, err |= (bresp!=0) and remaining -= chunk beats. Go to AW if remaining>0, else FIN.
  - FIN: busy=0, done=1 in the same cycle; go to IDLE.
- AW and W do not overlap; one burst is outstanding at a time. AXI valid signals stay stable until handshake.
- Data: wdata = {DATA_W/32{write_val}}; wstrb = all ones.
- cycle_count increments every cycle while busy and holds once done. It saturates at 32'hFFFF_FFFF and does not wrap.
- Arithmetic: the remaining counter is 32 bits; chunk address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- bid is ignored.

Test Plan:
- burst_len=4, start_addr=0x1000, write_val=0xA5A5_0001, always-ready slave -> one AW (awaddr=0x1000, awlen=3, awsize=6). Four beats, all lanes 0xA5A5_0001, wlast on beat 4. Then done=1, err=0, cycle_count=7.
- burst_len=130, MAX_BEATS=64, start_addr=0 -> three bursts: awaddr 0x0/0x1000/0x2000, awlen 63/63/1. 130 W beats total, done set after the third B.
- burst_len=0 -> no awvalid/wvalid ever. done=1 two cycles after start; cycle_count=1.
- Slave with random awready/wready/bvalid stalls (0-5 cycles) -> payload stable under valid, beat count exact, cycle_count equals the measured cycles.
- Slave returns bresp=2 on burst 2 of 3 -> run completes all bursts, err=1. A second start clears err to 0.
- rst held one cycle mid-W, then start during busy -> all outputs 0 after reset. A start pulse in a busy run is ignored: no new AW and latched burst_len unchanged.
